sata_link_rate_negotiator: RTL and testbench
============================================

Name: sata_link_rate_negotiator

Overview:
Upstream stage of the transceiver reconfiguration engine. Selects the SATA generation, issues reconfiguration commands through the cmd_reconfig/cmd_sata_gen/cmd_ready handshake, holds the transceiver in reset afterwards, and launches OOB attempts. On repeated OOB failure it steps down one generation (GEN3 -> GEN2 -> GEN1). It sits between the link/OOB controller and the reconfiguration engine.

Parameters:
RETRIES, 2, OOB attempts per generation before stepping down (>=1)
XRST_CYCLES, 16, clk cycles xcvr_reset is held after each completed reconfiguration (>=2)
TIMEOUT_CYCLES, 4096, reconfiguration watchdog limit (used only with SATA_NEG_TIMEOUT_EN)

Ports:
reset  input  1  asynchronous, active-high reset
clk  input  1  clock
ctl_start  input  1  level; start/restart negotiation from IDLE or FAIL
max_gen  input  2  highest generation allowed (`SATA_GEN1/2/3 from sata_defs.svh); sampled on start
oob_start  output  1  one-cycle pulse; begin an OOB sequence
oob_done  input  1  pulse; OOB complete, link established
oob_fail  input  1  pulse; OOB attempt timed out, or link lost while up
cmd_reconfig  output  1  reconfiguration request to the reconfiguration engine
cmd_sata_gen  output  2  requested generation; valid while cmd_reconfig=1
cmd_ready  input  1  engine idle/ready
xcvr_reset  output  1  transceiver datapath reset
cur_gen  output  2  currently configured generation
link_up  output  1  link established at cur_gen
neg_fail  output  1  negotiation exhausted all generations (sticky until restart)

Behaviour:
- Reset values: oob_start=0, cmd_reconfig=0, cmd_sata_gen=`SATA_GEN1, xcvr_reset=1, cur_gen=`SATA_GEN1, link_up=0, neg_fail=0. All outputs are registered.
- States: IDLE, REQ, RWAIT, XRST, OOB, OWAIT, LINK, FAIL.
- IDLE: xcvr_reset=1. On ctl_start: gen := max_gen, with 2'b00 or an invalid code treated as GEN1; attempt counter := 0; neg_fail := 0; go to REQ.
- REQ: cmd_reconfig=1 and cmd_sata_gen=gen. Acceptance is cmd_reconfig & cmd_ready in the same cycle. On acceptance, cmd_reconfig drops the next cycle and the FSM goes to RWAIT. If cmd_ready stays low, cmd_reconfig remains asserted.
- RWAIT:
  - cmd_ready is ignored on the first RWAIT cycle; the engine's ready deasserts one cycle after acceptance.
  - From the second cycle on, cmd_ready=1 -> cur_gen := gen and go to XRST.
- XRST: xcvr_reset=1 for exactly XRST_CYCLES cycles, then go to OOB. xcvr_reset is 1 in IDLE, REQ, RWAIT, XRST and FAIL, and 0 elsewhere.
- OOB: oob_start=1 for one cycle, then go to OWAIT.
- OWAIT:
  - oob_done -> LINK, link_up=1 from the next cycle.
  - oob_fail -> attempt+1. If attempt+1 < RETRIES, go to OOB (no reconfiguration).
  - Otherwise, if gen==GEN1, go to FAIL. Else gen := gen-1 step, attempt := 0, go to REQ.
  - oob_done and oob_fail in the same cycle: oob_done wins.
- LINK: link_up=1. oob_fail -> link_up=0, gen := max_gen (re-sampled), attempt := 0, go to REQ.
- FAIL: neg_fail=1, link_up=0. ctl_start restarts as from IDLE.
- ctl_start is ignored outside IDLE/FAIL. Reset mid-operation aborts immediately to reset values. The reconfiguration engine shares this reset, so no handshake cleanup is needed.
- Attempt counter width: $clog2(RETRIES+1). XRST counter width: $clog2(XRST_CYCLES).

Optional Feature:
SATA_NEG_TIMEOUT_EN
- Defined: a watchdog counter runs in REQ and RWAIT and clears on entering either from another state. Reaching TIMEOUT_CYCLES-1 forces FAIL with neg_fail=1 and cmd_reconfig=0.
- Undefined: no counter exists; the FSM waits indefinitely for cmd_ready.

Test Plan:
- max_gen=`SATA_GEN3, ctl_start, engine ready 3 cycles after acceptance, oob_done on first attempt -> exactly one cmd_reconfig acceptance with cmd_sata_gen=`SATA_GEN3; xcvr_reset high 16 cycles after ready returns; one oob_start pulse; link_up=1, cur_gen=`SATA_GEN3.
- max_gen=GEN3, oob_fail on every attempt -> 2 oob_start pulses per generation; reconfigurations to GEN3, GEN2, GEN1 in order; after 6th failure neg_fail=1, xcvr_reset=1.
- GEN3 fails twice, GEN2 oob_done -> cur_gen=`SATA_GEN2, link_up=1, neg_fail=0.
- cmd_ready held low for 100 cycles in REQ -> cmd_reconfig stays 1 throughout, no state advance; when cmd_ready rises, acceptance occurs in that cycle.
- In LINK, pulse oob_fail -> link_up=0 next cycle; new reconfiguration request at max_gen.
- reset asserted during XRST and during RWAIT -> outputs return to reset values asynchronously; with SATA_NEG_TIMEOUT_EN defined and cmd_ready stuck low, FAIL is reached after 4096 cycles.

Source files
------------

// File: rtl/sata_link_rate_negotiator.sv
// SATA link-rate negotiator: selects a generation, drives the reconfiguration handshake,
// holds the transceiver in reset, launches OOB and steps down on failure. Watchdog: SATA_NEG_TIMEOUT_EN.
`ifndef SATA_GEN1
`define SATA_GEN1 2'b01
`endif
`ifndef SATA_GEN2
`define SATA_GEN2 2'b10
`endif
`ifndef SATA_GEN3
`define SATA_GEN3 2'b11
`endif

module sata_link_rate_negotiator #(
  parameter int RETRIES        = 2,
  parameter int XRST_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       ctl_start,
  input  logic [1:0] max_gen,
  output logic       oob_start,
  input  logic       oob_done,
  input  logic       oob_fail,
  output logic       cmd_reconfig,
  output logic [1:0] cmd_sata_gen,
  input  logic       cmd_ready,
  output logic       xcvr_reset,
  output logic [1:0] cur_gen,
  output logic       link_up,
  output logic       neg_fail
);

  localparam int AW = $clog2(RETRIES + 1);
  localparam int XW = $clog2(XRST_CYCLES);
  localparam logic [AW-1:0] RETRY_LIM = AW'(RETRIES);
  localparam logic [XW-1:0] XRST_LAST = XW'(XRST_CYCLES - 1);
  localparam logic [1:0]    GEN1      = `SATA_GEN1;
  localparam logic [1:0]    GEN2      = `SATA_GEN2;
  localparam logic [1:0]    GEN3      = `SATA_GEN3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RWAIT = 3'd2,
    XRST  = 3'd3,
    OOB   = 3'd4,
    OWAIT = 3'd5,
    LINK  = 3'd6,
    FAIL  = 3'd7
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [1:0]    gen_r, gen_nxt_s;
  logic [1:0]    cur_gen_r, cur_gen_nxt_s;
  logic [AW-1:0] attempt_r, attempt_nxt_s, attempt_inc_s;
  logic [XW-1:0] xrst_cnt_r, xrst_cnt_nxt_s;
  logic          rwait_arm_r;
  logic          wd_expired_s;

  logic          oob_start_r, oob_start_nxt_s;
  logic          cmd_reconfig_r, cmd_reconfig_nxt_s;
  logic [1:0]    cmd_sata_gen_r;
  logic          xcvr_reset_r, xcvr_reset_nxt_s;
  logic          link_up_r, link_up_nxt_s;
  logic          neg_fail_r, neg_fail_nxt_s;

  // Out-of-range requests (only 2'b00 is unused) fall back to GEN1.
  function automatic logic [1:0] norm_gen(input logic [1:0] g);
    case (g)
      GEN1, GEN2, GEN3: norm_gen = g;
      default:          norm_gen = GEN1;
    endcase
  endfunction

  function automatic logic [1:0] step_down(input logic [1:0] g);
    case (g)
      GEN3:    step_down = GEN2;
      GEN2:    step_down = GEN1;
      default: step_down = GEN1;
    endcase
  endfunction

`ifdef SATA_NEG_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_cnt_r, wd_cnt_nxt_s;
  logic          in_hs_s, nxt_hs_s;

  // Watchdog spans REQ and RWAIT as one window; restarts on each fresh entry.
  always_comb begin
    in_hs_s      = (state_r == REQ) || (state_r == RWAIT);
    nxt_hs_s     = (state_nxt_s == REQ) || (state_nxt_s == RWAIT);
    wd_expired_s = in_hs_s && (wd_cnt_r == WD_LAST);
    if (in_hs_s && nxt_hs_s) begin
      wd_cnt_nxt_s = wd_cnt_r + WW'(1);
    end else begin
      wd_cnt_nxt_s = {WW{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= {WW{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_nxt_s;
    end
  end
`else
  assign wd_expired_s = 1'b0;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nxt_s    = state_r;
    gen_nxt_s      = gen_r;
    cur_gen_nxt_s  = cur_gen_r;
    attempt_nxt_s  = attempt_r;
    attempt_inc_s  = attempt_r + AW'(1);
    xrst_cnt_nxt_s = {XW{1'b0}};
    case (state_r)
      IDLE, FAIL: begin
        if (ctl_start) begin
          gen_nxt_s     = norm_gen(max_gen);
          attempt_nxt_s = {AW{1'b0}};
          state_nxt_s   = REQ;
        end else begin
          state_nxt_s   = state_r;
        end
      end
      REQ: begin
        if (wd_expired_s) begin
          state_nxt_s = FAIL;
        end else if (cmd_reconfig_r && cmd_ready) begin
          state_nxt_s = RWAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      RWAIT: begin
        // The engine's ready is still stale on the first cycle after acceptance.
        if (wd_expired_s) begin
          state_nxt_s = FAIL;
        end else if (rwait_arm_r && cmd_ready) begin
          cur_gen_nxt_s = gen_r;
          state_nxt_s   = XRST;
        end else begin
          state_nxt_s   = RWAIT;
        end
      end
      XRST: begin
        if (xrst_cnt_r == XRST_LAST) begin
          state_nxt_s    = OOB;
        end else begin
          xrst_cnt_nxt_s = xrst_cnt_r + XW'(1);
        end
      end
      OOB: begin
        state_nxt_s = OWAIT;
      end
      OWAIT: begin
        if (oob_done) begin
          state_nxt_s = LINK;
        end else if (oob_fail) begin
          if (attempt_inc_s < RETRY_LIM) begin
            attempt_nxt_s = attempt_inc_s;
            state_nxt_s   = OOB;
          end else if (gen_r == GEN1) begin
            attempt_nxt_s = attempt_inc_s;
            state_nxt_s   = FAIL;
          end else begin
            gen_nxt_s     = step_down(gen_r);
            attempt_nxt_s = {AW{1'b0}};
            state_nxt_s   = REQ;
          end
        end else begin
          state_nxt_s = OWAIT;
        end
      end
      LINK: begin
        if (oob_fail) begin
          gen_nxt_s     = norm_gen(max_gen);
          attempt_nxt_s = {AW{1'b0}};
          state_nxt_s   = REQ;
        end else begin
          state_nxt_s   = LINK;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies match the state.
  always_comb begin
    oob_start_nxt_s    = (state_nxt_s == OOB);
    cmd_reconfig_nxt_s = (state_nxt_s == REQ);
    link_up_nxt_s      = (state_nxt_s == LINK);
    neg_fail_nxt_s     = (state_nxt_s == FAIL);
    case (state_nxt_s)
      IDLE, REQ, RWAIT, XRST, FAIL: xcvr_reset_nxt_s = 1'b1;
      default:                      xcvr_reset_nxt_s = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      gen_r          <= GEN1;
      cur_gen_r      <= GEN1;
      attempt_r      <= {AW{1'b0}};
      xrst_cnt_r     <= {XW{1'b0}};
      rwait_arm_r    <= 1'b0;
      oob_start_r    <= 1'b0;
      cmd_reconfig_r <= 1'b0;
      cmd_sata_gen_r <= GEN1;
      xcvr_reset_r   <= 1'b1;
      link_up_r      <= 1'b0;
      neg_fail_r     <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      gen_r          <= gen_nxt_s;
      cur_gen_r      <= cur_gen_nxt_s;
      attempt_r      <= attempt_nxt_s;
      xrst_cnt_r     <= xrst_cnt_nxt_s;
      rwait_arm_r    <= (state_r == RWAIT);
      oob_start_r    <= oob_start_nxt_s;
      cmd_reconfig_r <= cmd_reconfig_nxt_s;
      cmd_sata_gen_r <= gen_nxt_s;
      xcvr_reset_r   <= xcvr_reset_nxt_s;
      link_up_r      <= link_up_nxt_s;
      neg_fail_r     <= neg_fail_nxt_s;
    end
  end

  assign oob_start    = oob_start_r;
  assign cmd_reconfig = cmd_reconfig_r;
  assign cmd_sata_gen = cmd_sata_gen_r;
  assign xcvr_reset   = xcvr_reset_r;
  assign cur_gen      = cur_gen_r;
  assign link_up      = link_up_r;
  assign neg_fail     = neg_fail_r;

endmodule

// File: tb/tb_sata_link_rate_negotiator.sv
// Scoreboard bench for sata_link_rate_negotiator: models the reconfiguration engine and the
// OOB controller; expected generations are queued at stimulus time and popped on each acceptance.
`ifndef SATA_GEN1
`define SATA_GEN1 2'b01
`endif
`ifndef SATA_GEN2
`define SATA_GEN2 2'b10
`endif
`ifndef SATA_GEN3
`define SATA_GEN3 2'b11
`endif

module tb_sata_link_rate_negotiator;

  localparam logic [1:0] G1 = `SATA_GEN1;
  localparam logic [1:0] G2 = `SATA_GEN2;
  localparam logic [1:0] G3 = `SATA_GEN3;
  localparam int ENG_DLY = 3;

  logic       reset, clk, ctl_start;
  logic [1:0] max_gen;
  logic       oob_start, oob_done, oob_fail;
  logic       cmd_reconfig, cmd_ready, xcvr_reset;
  logic [1:0] cmd_sata_gen, cur_gen;
  logic       link_up, neg_fail;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_gen_q[$];
  bit         oob_plan_q[$];
  int         acc_count, oob_pulses, eng_cnt, oob_delay, xr_cnt, xr_last;
  bit         oob_pending, oob_resp, hold_ready, xr_count_en;

  sata_link_rate_negotiator dut (
    .reset        (reset),
    .clk          (clk),
    .ctl_start    (ctl_start),
    .max_gen      (max_gen),
    .oob_start    (oob_start),
    .oob_done     (oob_done),
    .oob_fail     (oob_fail),
    .cmd_reconfig (cmd_reconfig),
    .cmd_sata_gen (cmd_sata_gen),
    .cmd_ready    (cmd_ready),
    .xcvr_reset   (xcvr_reset),
    .cur_gen      (cur_gen),
    .link_up      (link_up),
    .neg_fail     (neg_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: score acceptances and OOB pulses, then play engine and OOB controller.
  task automatic tick();
    bit acc;
    acc = cmd_reconfig && cmd_ready;
    if (acc) begin
      acc_count++;
      check_eq("reconfig_expected", exp_gen_q.size() > 0, 1);
      if (exp_gen_q.size() > 0) check_eq("reconfig_gen", cmd_sata_gen, exp_gen_q.pop_front());
    end
    if (oob_start) begin
      oob_pulses++;
      oob_pending = 1'b1;
      oob_resp    = (oob_plan_q.size() > 0) ? oob_plan_q.pop_front() : 1'b0;
      oob_delay   = 2;
    end
    @(posedge clk);
    #1;
    oob_done = 1'b0;
    oob_fail = 1'b0;
    if (xr_count_en) begin
      if (xcvr_reset) xr_cnt++;
      else begin
        xr_last     = xr_cnt;
        xr_count_en = 1'b0;
      end
    end
    if (!hold_ready) begin
      if (acc) begin
        cmd_ready = 1'b0;
        eng_cnt   = ENG_DLY;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          cmd_ready   = 1'b1;
          xr_count_en = 1'b1;
          xr_cnt      = 0;
        end
      end
    end
    if (oob_pending) begin
      if (oob_delay == 0) begin
        if (oob_resp) oob_done = 1'b1;
        else          oob_fail = 1'b1;
        oob_pending = 1'b0;
      end else begin
        oob_delay--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; ctl_start = 1'b0; oob_done = 1'b0; oob_fail = 1'b0;
    cmd_ready = 1'b1; max_gen = G3;
    exp_gen_q.delete(); oob_plan_q.delete();
    acc_count = 0; oob_pulses = 0; eng_cnt = 0; oob_delay = 0;
    oob_pending = 1'b0; hold_ready = 1'b0; xr_count_en = 1'b0; xr_cnt = 0; xr_last = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_neg();
    ctl_start = 1'b1;
    tick();
    ctl_start = 1'b0;
  endtask

  task automatic wait_link(input int budget);
    for (int i = 0; i < budget && !link_up; i++) tick();
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_oob_start"},    oob_start,    0);
    check_eq({pfx, "_cmd_reconfig"}, cmd_reconfig, 0);
    check_eq({pfx, "_cmd_sata_gen"}, cmd_sata_gen, G1);
    check_eq({pfx, "_xcvr_reset"},   xcvr_reset,   1);
    check_eq({pfx, "_cur_gen"},      cur_gen,      G1);
    check_eq({pfx, "_link_up"},      link_up,      0);
    check_eq({pfx, "_neg_fail"},     neg_fail,     0);
  endtask

  initial begin
    int a0, hi_cnt, p0;
    do_reset();
    check_reset_vals("rst");

    // Straight GEN3 link-up on the first attempt.
    max_gen = G3;
    exp_gen_q.push_back(G3);
    oob_plan_q.push_back(1'b1);
    start_neg();
    check_eq("req_after_start", cmd_reconfig, 1);
    wait_link(200);
    check_eq("s1_link_up", link_up, 1);
    check_eq("s1_cur_gen", cur_gen, G3);
    check_eq("s1_accepts", acc_count, 1);
    check_eq("s1_oob_pulses", oob_pulses, 1);
    check_eq("s1_xrst_len", xr_last, 16);
    check_eq("s1_xcvr_reset", xcvr_reset, 0);
    check_eq("s1_neg_fail", neg_fail, 0);

    // Link loss: re-sample max_gen and reconfigure.
    max_gen = G2;
    exp_gen_q.push_back(G2);
    oob_plan_q.push_back(1'b1);
    oob_fail = 1'b1;
    tick();
    check_eq("loss_link_up", link_up, 0);
    check_eq("loss_cmd_reconfig", cmd_reconfig, 1);
    check_eq("loss_cmd_gen", cmd_sata_gen, G2);
    wait_link(200);
    check_eq("loss_relink", link_up, 1);
    check_eq("loss_cur_gen", cur_gen, G2);

    // Engine not ready for 100 cycles: request must hold.
    hold_ready = 1'b1;
    cmd_ready  = 1'b0;
    max_gen    = G3;
    exp_gen_q.push_back(G3);
    oob_plan_q.push_back(1'b1);
    oob_fail = 1'b1;
    tick();
    a0 = acc_count;
    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_reconfig && xcvr_reset) hi_cnt++;
      tick();
    end
    check_eq("stall_req_held", hi_cnt, 100);
    check_eq("stall_no_accept", acc_count, a0);
    cmd_ready  = 1'b1;
    hold_ready = 1'b0;
    tick();
    check_eq("stall_accept", acc_count, a0 + 1);
    check_eq("stall_req_drop", cmd_reconfig, 0);
    wait_link(200);
    check_eq("stall_cur_gen", cur_gen, G3);
    check_eq("stall_queue_empty", exp_gen_q.size(), 0);

    // Every attempt fails: GEN3 -> GEN2 -> GEN1 -> FAIL.
    do_reset();
    max_gen = G3;
    exp_gen_q.push_back(G3); exp_gen_q.push_back(G2); exp_gen_q.push_back(G1);
    for (int i = 0; i < 6; i++) oob_plan_q.push_back(1'b0);
    start_neg();
    for (int i = 0; i < 600 && !neg_fail; i++) tick();
    check_eq("fail_neg_fail", neg_fail, 1);
    check_eq("fail_xcvr_reset", xcvr_reset, 1);
    check_eq("fail_link_up", link_up, 0);
    check_eq("fail_oob_pulses", oob_pulses, 6);
    check_eq("fail_accepts", acc_count, 3);
    check_eq("fail_queue_empty", exp_gen_q.size(), 0);
    check_eq("fail_cur_gen", cur_gen, G1);
    p0 = oob_pulses;
    repeat (10) tick();
    check_eq("fail_sticky", neg_fail, 1);
    check_eq("fail_quiet", oob_pulses, p0);

    // Restart from FAIL with an invalid max_gen code: GEN1.
    max_gen = 2'b00;
    exp_gen_q.push_back(G1);
    oob_plan_q.push_back(1'b1);
    start_neg();
    check_eq("restart_neg_fail", neg_fail, 0);
    wait_link(200);
    check_eq("restart_link", link_up, 1);
    check_eq("restart_cur_gen", cur_gen, G1);

    // GEN3 fails twice, GEN2 links.
    do_reset();
    max_gen = G3;
    exp_gen_q.push_back(G3); exp_gen_q.push_back(G2);
    oob_plan_q.push_back(1'b0); oob_plan_q.push_back(1'b0); oob_plan_q.push_back(1'b1);
    start_neg();
    wait_link(400);
    check_eq("s3_link_up", link_up, 1);
    check_eq("s3_cur_gen", cur_gen, G2);
    check_eq("s3_neg_fail", neg_fail, 0);
    check_eq("s3_oob_pulses", oob_pulses, 3);
    check_eq("s3_queue_empty", exp_gen_q.size(), 0);

    // Asynchronous reset during XRST.
    do_reset();
    exp_gen_q.push_back(G3);
    start_neg();
    for (int i = 0; i < 100 && !(xr_count_en && xr_cnt >= 5); i++) tick();
    check_eq("xrst_reached", xr_cnt >= 5, 1);
    check_eq("xrst_cur_gen_pre", cur_gen, G3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_xrst");

    // Asynchronous reset during RWAIT.
    do_reset();
    exp_gen_q.push_back(G3);
    start_neg();
    for (int i = 0; i < 100 && acc_count == 0; i++) tick();
    check_eq("rwait_reached", acc_count, 1);
    check_eq("rwait_gen_pre", cmd_sata_gen, G3);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("rst_rwait");

`ifdef SATA_NEG_TIMEOUT_EN
    // Engine never ready: watchdog forces FAIL after 4096 handshake cycles.
    do_reset();
    hold_ready = 1'b1;
    cmd_ready  = 1'b0;
    start_neg();
    hi_cnt = 0;
    for (int i = 0; i < 5000 && !neg_fail; i++) begin
      if (cmd_reconfig) hi_cnt++;
      tick();
    end
    check_eq("wd_neg_fail", neg_fail, 1);
    check_eq("wd_cmd_reconfig", cmd_reconfig, 0);
    check_eq("wd_req_cycles", hi_cnt, 4096);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
